wifire_rx_ctrl: RTL and testbench
=================================

WIFIRE_RX_CTRL -- requirements
Module: wifire_rx_ctrl

Interface
REQ-001 Parameter FIFO_AW, default 7, log2 of payload buffer depth (128 bytes).
REQ-002 Parameter TIMEOUT, default 4096, max clk cycles between MSDU strobes before abort.
REQ-003 clk  in  1  clock; reset  in  1  reset, asynchronous, active-low.
REQ-004 en  in  1  controller enable; local_pan_i  in  16  own PAN ID; local_short_i  in  16  own short address; local_ext_i  in  64  own extended address; promisc_i  in  1  bypass address filter.
REQ-005 dec_en_o  out  1  enable to frame decoder; rcv_sfd_i  in  1  SFD strobe from receiver.
REQ-006 valid_len_i  in  1, len_i  in  7, valid_frame_ctrl_i  in  1, frame_ctrl_i  in  16, valid_addr_i  in  1, dst_pan_i  in  16, dst_addr_i  in  64  decoder header fields.
REQ-007 msdu_i  in  8, msdu_stb_i  in  1  decoder payload byte stream (FCS included).
REQ-008 rd_en_i  in  1  host pop; rd_data_o  out  8  head byte; rd_empty_o  out  1  no committed bytes.
REQ-009 frame_rdy_o  out  1  pulse, frame committed; frame_len_o  out  7  committed payload length; drop_o  out  1  pulse, frame discarded; drop_cnt_o  out  16  saturating drop counter.

Function
REQ-010 dec_en_o SHALL equal en registered; en low SHALL force state IDLE without touching committed data.
REQ-011 States SHALL be IDLE, HDR, FILTER, PAYLOAD, COMMIT, DROP.
REQ-012 IDLE->HDR on rcv_sfd_i; HDR->FILTER once valid_len_i, valid_frame_ctrl_i and valid_addr_i are all high.
REQ-013 hdr_len SHALL be 3 + dst_bytes + src_bytes; dst mode 2->4, 3->10, else 0; src mode 2->2, 3->8, else 0, plus 2 if src mode nonzero and frame_ctrl_i[6]=0.
REQ-014 payload_len SHALL be len_i - hdr_len in 8 bits; hdr_len > len_i SHALL go to DROP.
REQ-015 Filter accept when promisc_i, or dst mode 0, or (dst_pan_i in {local_pan_i,16'hFFFF} and (mode 2: dst_addr_i[15:0] in {local_short_i,16'hFFFF}; mode 3: dst_addr_i==local_ext_i)); dst mode 1 always rejected unless promisc_i.
REQ-016 FILTER SHALL take exactly one cycle; accept->PAYLOAD (or COMMIT if payload_len==0), reject->DROP.
REQ-017 In PAYLOAD each msdu_stb_i SHALL write msdu_i at the speculative write pointer and increment byte count; count==payload_len->COMMIT.
REQ-018 COMMIT SHALL copy speculative pointer to committed pointer, pulse frame_rdy_o one cycle, load frame_len_o, return IDLE.
REQ-019 DROP SHALL rewind speculative pointer to committed pointer, pulse drop_o one cycle, increment drop_cnt_o (saturate at 16'hFFFF), return IDLE.
REQ-020 Buffer full at a PAYLOAD write SHALL go to DROP; byte not written.
REQ-021 No msdu_stb_i for TIMEOUT cycles in PAYLOAD SHALL go to DROP.
REQ-022 rcv_sfd_i in HDR/FILTER/PAYLOAD SHALL discard the partial frame (no drop_o) and restart HDR the next cycle.
REQ-023 Reads SHALL see only committed bytes; rd_data_o valid same cycle rd_empty_o is low; rd_en_i while empty ignored; simultaneous read and write allowed.
REQ-024 Pointers SHALL be FIFO_AW+1 bits, full/empty by MSB compare; wrap-around transparent.

Reset
REQ-025 Reset SHALL set state IDLE, all pointers 0, dec_en_o 0, frame_rdy_o 0, drop_o 0, frame_len_o 0, drop_cnt_o 0, rd_empty_o 1; buffer RAM not reset.

Structure
REQ-026 State encoding, address-mode constants (NONE=0, SHORT=2, EXT=3) and broadcast 16'hFFFF SHALL live in the shared wifire package.
REQ-027 Payload storage SHALL be sub-module wifire_rx_fifo (RAM, committed/speculative pointers, rewind, commit).

Verification
REQ-028 Accepted frame: pan CAFE, dst short BEEF matches, len 17, 8 payload bytes -> frame_rdy_o pulse, frame_len_o 8, 8 bytes read in order.
REQ-029 Mismatched dst 1234, promisc 0 -> drop_o pulse, drop_cnt_o 1, rd_empty_o stays 1; same frame promisc 1 -> committed.
REQ-030 Broadcast dst FFFF/FFFF -> accepted; ext-address frame matching local_ext_i -> accepted.
REQ-031 SFD after 3 payload bytes, then full valid frame -> only second frame committed, drop_cnt_o unchanged.
REQ-032 Buffer holds 125 unread bytes, 8-byte frame arrives -> DROP, earlier data intact; stalled payload 4096 cycles -> drop_o.
REQ-033 reset asserted mid-PAYLOAD -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/wifire_pkg.sv
// Shared definitions for the WiFire receive path: controller states,
// 802.15.4 address modes and header-length arithmetic.
package wifire_pkg;

   localparam int unsigned LEN_W  = 7;
   localparam int unsigned PLEN_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_FILTER,
      ST_PAYLOAD,
      ST_COMMIT,
      ST_DROP
   } rx_state_e;

   localparam logic [1:0]  ADDR_NONE  = 2'd0;
   localparam logic [1:0]  ADDR_SHORT = 2'd2;
   localparam logic [1:0]  ADDR_EXT   = 2'd3;
   localparam logic [15:0] BCAST_ID   = 16'hFFFF;

   // Header verdict captured once all decoder fields are valid
   typedef struct packed {
      logic              accept;
      logic              len_bad;
      logic [PLEN_W-1:0] payload_len;
   } hdr_info_t;

   function automatic logic [PLEN_W-1:0] hdr_len(input logic [1:0] dst_mode,
                                                 input logic [1:0] src_mode,
                                                 input logic       pan_comp);
      logic [PLEN_W-1:0] n;
      n = PLEN_W'(3);
      case (dst_mode)
         ADDR_SHORT: n = n + PLEN_W'(4);
         ADDR_EXT:   n = n + PLEN_W'(10);
         default:    n = n;
      endcase
      case (src_mode)
         ADDR_SHORT: n = n + PLEN_W'(2);
         ADDR_EXT:   n = n + PLEN_W'(8);
         default:    n = n;
      endcase
      if ((src_mode != ADDR_NONE) && !pan_comp) n = n + PLEN_W'(2);
      return n;
   endfunction

endpackage

// File: rtl/wifire_rx_fifo.sv
// Payload byte buffer with a speculative write pointer that is either
// committed (frame accepted) or rewound (frame discarded).
module wifire_rx_fifo #(
   parameter int unsigned FIFO_AW = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en_i,
   input  logic [7:0] wr_data_i,
   input  logic       commit_i,
   input  logic       rewind_i,
   input  logic       rd_en_i,
   output logic [7:0] rd_data_o,
   output logic       empty_o,
   output logic       full_o
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned PW    = FIFO_AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] cmt_ptr_q, cmt_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          do_wr, do_rd;

   // Full is judged against the reader so speculative bytes also consume space
   always_comb begin
      full_o    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
      empty_o   = (rd_ptr_q == cmt_ptr_q);
      do_wr     = wr_en_i && !full_o && !rewind_i;
      do_rd     = rd_en_i && !empty_o;
      wr_ptr_d  = wr_ptr_q;
      cmt_ptr_d = cmt_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (rewind_i)   wr_ptr_d  = cmt_ptr_q;
      else if (do_wr) wr_ptr_d  = wr_ptr_q + PW'(1);
      if (commit_i)   cmt_ptr_d = wr_ptr_q;
      if (do_rd)      rd_ptr_d  = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         cmt_ptr_q <= '0;
         rd_ptr_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         cmt_ptr_q <= cmt_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_data_i;
   end

   assign rd_data_o = mem[rd_ptr_q[FIFO_AW-1:0]];

endmodule

// File: rtl/wifire_rx_ctrl.sv
// Receive controller: parses decoder header fields, filters on address,
// stages payload bytes in the FIFO and commits or discards each frame.
module wifire_rx_ctrl
   import wifire_pkg::*;
#(
   parameter int unsigned FIFO_AW = 7,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [15:0]       local_pan_i,
   input  logic [15:0]       local_short_i,
   input  logic [63:0]       local_ext_i,
   input  logic              promisc_i,
   output logic              dec_en_o,
   input  logic              rcv_sfd_i,
   input  logic              valid_len_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              valid_frame_ctrl_i,
   input  logic [15:0]       frame_ctrl_i,
   input  logic              valid_addr_i,
   input  logic [15:0]       dst_pan_i,
   input  logic [63:0]       dst_addr_i,
   input  logic [7:0]        msdu_i,
   input  logic              msdu_stb_i,
   input  logic              rd_en_i,
   output logic [7:0]        rd_data_o,
   output logic              rd_empty_o,
   output logic              frame_rdy_o,
   output logic [LEN_W-1:0]  frame_len_o,
   output logic              drop_o,
   output logic [15:0]       drop_cnt_o
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   rx_state_e          state_q, state_d;
   hdr_info_t          hdr_q, hdr_d, hdr_new;
   logic [PLEN_W-1:0]  cnt_q, cnt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               dec_en_q, dec_en_d;
   logic               frame_rdy_q, frame_rdy_d;
   logic               drop_q, drop_d;
   logic [LEN_W-1:0]   frame_len_q, frame_len_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic               fifo_wr, fifo_commit, fifo_rewind, fifo_full;
   logic [1:0]         dst_mode, src_mode;
   logic [PLEN_W-1:0]  hlen, len_ext;
   logic               pan_ok, addr_ok;
   logic               unused_fc;

   // Frame-control bits the controller does not interpret
   assign unused_fc = ^{frame_ctrl_i[13:12], frame_ctrl_i[9:7], frame_ctrl_i[5:0]};

   // Header length and address filter verdict from the live decoder fields
   always_comb begin
      dst_mode = frame_ctrl_i[11:10];
      src_mode = frame_ctrl_i[15:14];
      hlen     = hdr_len(dst_mode, src_mode, frame_ctrl_i[6]);
      len_ext  = PLEN_W'(len_i);
      pan_ok   = (dst_pan_i == local_pan_i) || (dst_pan_i == BCAST_ID);
      case (dst_mode)
         ADDR_NONE:  addr_ok = 1'b1;
         ADDR_SHORT: addr_ok = pan_ok && ((dst_addr_i[15:0] == local_short_i) ||
                                          (dst_addr_i[15:0] == BCAST_ID));
         ADDR_EXT:   addr_ok = pan_ok && (dst_addr_i == local_ext_i);
         default:    addr_ok = 1'b0;
      endcase
      hdr_new.accept      = promisc_i || addr_ok;
      hdr_new.len_bad     = hlen > len_ext;
      hdr_new.payload_len = len_ext - hlen;
   end

   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      dec_en_d    = en;
      frame_rdy_d = 1'b0;
      drop_d      = 1'b0;
      frame_len_d = frame_len_q;
      drop_cnt_d  = drop_cnt_q;
      fifo_wr     = 1'b0;
      fifo_commit = 1'b0;
      fifo_rewind = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rcv_sfd_i) state_d = ST_HDR;
         end
         ST_HDR: begin
            if (rcv_sfd_i) begin
               state_d = ST_HDR;
            end else if (valid_len_i && valid_frame_ctrl_i && valid_addr_i) begin
               hdr_d   = hdr_new;
               state_d = ST_FILTER;
            end
         end
         ST_FILTER: begin
            cnt_d   = '0;
            timer_d = '0;
            if (rcv_sfd_i) begin
               fifo_rewind = 1'b1;
               state_d     = ST_HDR;
            end else if (!hdr_q.accept || hdr_q.len_bad) begin
               state_d = ST_DROP;
            end else if (hdr_q.payload_len == '0) begin
               state_d = ST_COMMIT;
            end else begin
               state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (rcv_sfd_i) begin
               fifo_rewind = 1'b1;
               state_d     = ST_HDR;
            end else if (msdu_stb_i) begin
               timer_d = '0;
               if (fifo_full) begin
                  state_d = ST_DROP;
               end else begin
                  fifo_wr = 1'b1;
                  cnt_d   = cnt_q + PLEN_W'(1);
                  if (cnt_d == hdr_q.payload_len) state_d = ST_COMMIT;
               end
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               state_d = ST_DROP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_COMMIT: begin
            fifo_commit = 1'b1;
            frame_rdy_d = 1'b1;
            frame_len_d = hdr_q.payload_len[LEN_W-1:0];
            state_d     = rcv_sfd_i ? ST_HDR : ST_IDLE;
         end
         ST_DROP: begin
            fifo_rewind = 1'b1;
            drop_d      = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            state_d     = rcv_sfd_i ? ST_HDR : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Disable abandons any in-flight frame quietly; a pending commit still lands
      if (!en) begin
         state_d = ST_IDLE;
         if ((state_q == ST_HDR) || (state_q == ST_FILTER) || (state_q == ST_PAYLOAD)) begin
            fifo_wr     = 1'b0;
            fifo_rewind = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         hdr_q       <= '0;
         cnt_q       <= '0;
         timer_q     <= '0;
         dec_en_q    <= 1'b0;
         frame_rdy_q <= 1'b0;
         drop_q      <= 1'b0;
         frame_len_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         hdr_q       <= hdr_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         dec_en_q    <= dec_en_d;
         frame_rdy_q <= frame_rdy_d;
         drop_q      <= drop_d;
         frame_len_q <= frame_len_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign dec_en_o    = dec_en_q;
   assign frame_rdy_o = frame_rdy_q;
   assign drop_o      = drop_q;
   assign frame_len_o = frame_len_q;
   assign drop_cnt_o  = drop_cnt_q;

   wifire_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (fifo_wr),
      .wr_data_i (msdu_i),
      .commit_i  (fifo_commit),
      .rewind_i  (fifo_rewind),
      .rd_en_i   (rd_en_i),
      .rd_data_o (rd_data_o),
      .empty_o   (rd_empty_o),
      .full_o    (fifo_full)
   );

endmodule

// File: tb/tb_wifire_rx_ctrl.sv
// Self-checking bench for wifire_rx_ctrl: committed payload bytes go into a
// scoreboard queue and are compared as the host pops them.
module tb_wifire_rx_ctrl;

   localparam int unsigned TIMEOUT  = 4096;
   localparam logic [15:0] MY_PAN   = 16'hCAFE;
   localparam logic [15:0] MY_SHORT = 16'hBEEF;
   localparam logic [63:0] MY_EXT   = 64'h0123_4567_89AB_CDEF;

   logic        clk, reset, en, promisc_i, dec_en_o, rcv_sfd_i;
   logic        valid_len_i, valid_frame_ctrl_i, valid_addr_i;
   logic [6:0]  len_i, frame_len_o;
   logic [15:0] frame_ctrl_i, dst_pan_i, drop_cnt_o;
   logic [63:0] dst_addr_i;
   logic [7:0]  msdu_i, rd_data_o;
   logic        msdu_stb_i, rd_en_i, rd_empty_o, frame_rdy_o, drop_o;

   int          n_checks, n_fail, n_rdy, n_drop, exp_drops;
   logic [6:0]  last_len;
   logic [7:0]  exp_q[$];

   wifire_rx_ctrl #(.FIFO_AW(7), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .en(en),
      .local_pan_i(MY_PAN), .local_short_i(MY_SHORT), .local_ext_i(MY_EXT),
      .promisc_i(promisc_i), .dec_en_o(dec_en_o), .rcv_sfd_i(rcv_sfd_i),
      .valid_len_i(valid_len_i), .len_i(len_i),
      .valid_frame_ctrl_i(valid_frame_ctrl_i), .frame_ctrl_i(frame_ctrl_i),
      .valid_addr_i(valid_addr_i), .dst_pan_i(dst_pan_i), .dst_addr_i(dst_addr_i),
      .msdu_i(msdu_i), .msdu_stb_i(msdu_stb_i),
      .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_empty_o(rd_empty_o),
      .frame_rdy_o(frame_rdy_o), .frame_len_o(frame_len_o),
      .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event recorder for the one-cycle pulses
   always @(negedge clk) begin
      if (reset) begin
         if (frame_rdy_o) begin
            n_rdy++;
            last_len = frame_len_o;
         end
         if (drop_o) n_drop++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_frame(input logic [15:0] fc, input logic [6:0] len,
                             input logic [15:0] pan, input logic [63:0] addr,
                             input int nbytes, input bit keep);
      logic [7:0] b;
      rcv_sfd_i = 1'b1;
      tick();
      rcv_sfd_i          = 1'b0;
      frame_ctrl_i       = fc;
      len_i              = len;
      dst_pan_i          = pan;
      dst_addr_i         = addr;
      valid_len_i        = 1'b1;
      valid_frame_ctrl_i = 1'b1;
      valid_addr_i       = 1'b1;
      tick();
      valid_len_i        = 1'b0;
      valid_frame_ctrl_i = 1'b0;
      valid_addr_i       = 1'b0;
      settle(2);
      for (int i = 0; i < nbytes; i++) begin
         b          = 8'($urandom);
         msdu_i     = b;
         msdu_stb_i = 1'b1;
         if (keep) exp_q.push_back(b);
         tick();
         msdu_stb_i = 1'b0;
         if (i % 3 == 2) tick();
      end
   endtask

   // Scoreboard consumer: pop every expected byte from the DUT in order
   task automatic drain(input string tag);
      logic [7:0] e;
      int         n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (rd_empty_o !== 1'b0 || rd_data_o !== e) begin
            n_fail++;
            $display("FAIL %s byte %0d: got %h (empty=%b), expected %h (empty=0)",
                     tag, i, rd_data_o, rd_empty_o, e);
         end
         rd_en_i = 1'b1;
         tick();
         rd_en_i = 1'b0;
      end
      n_checks++;
      if (rd_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s empty after drain: got %b, expected 1", tag, rd_empty_o);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b0; promisc_i = 1'b0; rcv_sfd_i = 1'b0;
      valid_len_i = 1'b0; valid_frame_ctrl_i = 1'b0; valid_addr_i = 1'b0;
      len_i = '0; frame_ctrl_i = '0; dst_pan_i = '0; dst_addr_i = '0;
      msdu_i = '0; msdu_stb_i = 1'b0; rd_en_i = 1'b0;
      settle(3);
      n_checks++;
      if ({dec_en_o, frame_rdy_o, drop_o, frame_len_o, drop_cnt_o, rd_empty_o} !== {3'b000, 7'd0, 16'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_values: got dec_en=%b rdy=%b drop=%b len=%0d cnt=%0d empty=%b, expected 0 0 0 0 0 1",
                  dec_en_o, frame_rdy_o, drop_o, frame_len_o, drop_cnt_o, rd_empty_o);
      end
      reset = 1'b1;
      tick();
      en = 1'b1;
      settle(2);
      n_checks++;
      if (dec_en_o !== 1'b1) begin
         n_fail++;
         $display("FAIL dec_en_follows_en: got %b, expected 1", dec_en_o);
      end
   endtask

   task automatic test_accept();
      int r0, d0;
      r0 = n_rdy; d0 = n_drop;
      send_frame(16'h8841, 7'd17, MY_PAN, 64'(MY_SHORT), 8, 1'b1);
      settle(5);
      n_checks++;
      if (n_rdy - r0 !== 1 || n_drop - d0 !== 0 || last_len !== 7'd8) begin
         n_fail++;
         $display("FAIL accept_short: got rdy=%0d drop=%0d len=%0d, expected 1 0 8",
                  n_rdy - r0, n_drop - d0, last_len);
      end
      drain("accept_short");
   endtask

   task automatic test_filter();
      int r0, d0;
      r0 = n_rdy; d0 = n_drop;
      send_frame(16'h8841, 7'd17, MY_PAN, 64'h1234, 8, 1'b0);
      settle(5);
      exp_drops++;
      n_checks++;
      if (n_drop - d0 !== 1 || n_rdy - r0 !== 0 || drop_cnt_o !== 16'(exp_drops) || rd_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mismatch_drop: got drop=%0d rdy=%0d cnt=%0d empty=%b, expected 1 0 %0d 1",
                  n_drop - d0, n_rdy - r0, drop_cnt_o, rd_empty_o, exp_drops);
      end
      promisc_i = 1'b1;
      r0 = n_rdy;
      send_frame(16'h8841, 7'd17, MY_PAN, 64'h1234, 8, 1'b1);
      settle(5);
      promisc_i = 1'b0;
      n_checks++;
      if (n_rdy - r0 !== 1 || last_len !== 7'd8) begin
         n_fail++;
         $display("FAIL promisc_accept: got rdy=%0d len=%0d, expected 1 8", n_rdy - r0, last_len);
      end
      drain("promisc_accept");
   endtask

   // Header-length and address-filter corner cases
   task automatic test_header_variants();
      logic [15:0] fc  [9] = '{16'h8841, 16'hCC41, 16'hCC41, 16'h8041, 16'h8801,
                               16'h8441, 16'h8841, 16'h8841, 16'h8841};
      logic [6:0]  ln  [9] = '{7'd13, 7'd27, 7'd27, 7'd9, 7'd16, 7'd9, 7'd5, 7'd9, 7'd15};
      logic [15:0] pan [9] = '{16'hFFFF, MY_PAN, MY_PAN, 16'h0001, MY_PAN,
                               MY_PAN, MY_PAN, MY_PAN, 16'hFFFF};
      logic [63:0] adr [9] = '{64'hFFFF, MY_EXT, MY_EXT ^ 64'h1, 64'h0, 64'(MY_SHORT),
                               64'(MY_SHORT), 64'(MY_SHORT), 64'(MY_SHORT), 64'(MY_SHORT)};
      int          pl  [9] = '{4, 6, 6, 4, 5, 4, 0, 0, 6};
      bit          acc [9] = '{1, 1, 0, 1, 1, 0, 0, 1, 1};
      int r0, d0;
      for (int k = 0; k < 9; k++) begin
         r0 = n_rdy; d0 = n_drop;
         send_frame(fc[k], ln[k], pan[k], adr[k], pl[k], acc[k]);
         settle(5);
         if (!acc[k]) exp_drops++;
         n_checks++;
         if (n_rdy - r0 !== int'(acc[k]) || n_drop - d0 !== int'(!acc[k]) ||
             (acc[k] && last_len !== 7'(pl[k])) || drop_cnt_o !== 16'(exp_drops)) begin
            n_fail++;
            $display("FAIL hdr_case_%0d: got rdy=%0d drop=%0d len=%0d cnt=%0d, expected %0d %0d %0d %0d",
                     k, n_rdy - r0, n_drop - d0, last_len, drop_cnt_o,
                     int'(acc[k]), int'(!acc[k]), pl[k], exp_drops);
         end
         drain($sformatf("hdr_case_%0d", k));
      end
   endtask

   task automatic test_sfd_restart();
      int r0, d0;
      r0 = n_rdy; d0 = n_drop;
      send_frame(16'h8841, 7'd17, MY_PAN, 64'(MY_SHORT), 3, 1'b0);
      send_frame(16'h8841, 7'd17, MY_PAN, 64'(MY_SHORT), 8, 1'b1);
      settle(5);
      n_checks++;
      if (n_rdy - r0 !== 1 || n_drop - d0 !== 0 || drop_cnt_o !== 16'(exp_drops) || last_len !== 7'd8) begin
         n_fail++;
         $display("FAIL sfd_restart: got rdy=%0d drop=%0d cnt=%0d len=%0d, expected 1 0 %0d 8",
                  n_rdy - r0, n_drop - d0, drop_cnt_o, last_len, exp_drops);
      end
      drain("sfd_restart");
   endtask

   task automatic test_buffer_full();
      int r0, d0;
      r0 = n_rdy; d0 = n_drop;
      for (int k = 0; k < 5; k++) begin
         send_frame(16'h8841, 7'd34, MY_PAN, 64'(MY_SHORT), 25, 1'b1);
         settle(5);
      end
      send_frame(16'h8841, 7'd17, MY_PAN, 64'(MY_SHORT), 8, 1'b0);
      settle(5);
      exp_drops++;
      n_checks++;
      if (n_rdy - r0 !== 5 || n_drop - d0 !== 1 || drop_cnt_o !== 16'(exp_drops)) begin
         n_fail++;
         $display("FAIL buffer_full: got rdy=%0d drop=%0d cnt=%0d, expected 5 1 %0d",
                  n_rdy - r0, n_drop - d0, drop_cnt_o, exp_drops);
      end
      drain("buffer_full");
   endtask

   task automatic test_timeout();
      int d0, waited;
      d0 = n_drop;
      send_frame(16'h8841, 7'd17, MY_PAN, 64'(MY_SHORT), 2, 1'b0);
      waited = 0;
      while (n_drop == d0 && waited < int'(TIMEOUT) + 200) begin
         tick();
         waited++;
      end
      exp_drops++;
      n_checks++;
      if (n_drop - d0 !== 1 || waited < int'(TIMEOUT) - 8 || waited > int'(TIMEOUT) + 8 ||
          drop_cnt_o !== 16'(exp_drops)) begin
         n_fail++;
         $display("FAIL stall_timeout: got drop=%0d after %0d cycles cnt=%0d, expected 1 after ~%0d cycles cnt=%0d",
                  n_drop - d0, waited, drop_cnt_o, TIMEOUT, exp_drops);
      end
      drain("stall_timeout");
   endtask

   task automatic test_reset_mid_payload();
      send_frame(16'h8841, 7'd17, MY_PAN, 64'(MY_SHORT), 8, 1'b0);
      settle(5);
      send_frame(16'h8841, 7'd17, MY_PAN, 64'(MY_SHORT), 3, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({dec_en_o, frame_rdy_o, drop_o, frame_len_o, drop_cnt_o, rd_empty_o} !== {3'b000, 7'd0, 16'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_payload: got dec_en=%b rdy=%b drop=%b len=%0d cnt=%0d empty=%b, expected 0 0 0 0 0 1",
                  dec_en_o, frame_rdy_o, drop_o, frame_len_o, drop_cnt_o, rd_empty_o);
      end
      exp_q.delete();
      exp_drops = 0;
      settle(2);
      reset = 1'b1;
      settle(2);
      test_accept();
   endtask

   initial begin
      n_checks = 0; n_fail = 0; n_rdy = 0; n_drop = 0; exp_drops = 0; last_len = '0;
      test_reset();
      test_accept();
      test_filter();
      test_header_variants();
      test_sfd_restart();
      test_buffer_full();
      test_timeout();
      test_reset_mid_payload();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
